// File: rtl/dmac_read_initiator.sv
// dmac_read_initiator: AXI4 read-channel master for the DMA controller.
// It accepts burst descriptors from the channel scheduler and issues them on AR.
// Returned R beats pass through a 2-entry skid buffer onto a valid/ready stream.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   rd_req_*           burst descriptor input (valid/ready, addr, burst, len, size)
//   data_out_*         read beat stream to the realignment/FIFO stage
//   rd_err             sticky error: non-OKAY rresp (or rlast mismatch, see below)
//   rd_busy            AR pending, bursts outstanding, or skid buffer non-empty
//   m_axi_ar*/m_axi_r* AXI4 read address and read data channels
//
// Optional feature macro: DMAC_RD_LAST_CHECK_EN
//   When defined, the arlen of every issued burst is queued and the R beats are
//   counted against it. An early or missing rlast sets rd_err, and data_out_last
//   comes from the expected beat count instead of rlast.
module dmac_read_initiator #(
  parameter int unsigned ADDR_WD         = 32,
  parameter int unsigned DATA_WD         = 32,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rd_req_valid,
  output logic               rd_req_ready,
  input  logic [ADDR_WD-1:0] rd_req_addr,
  input  logic [1:0]         rd_req_burst,
  input  logic [7:0]         rd_req_len,
  input  logic [2:0]         rd_req_size,
  output logic               data_out_valid,
  input  logic               data_out_ready,
  output logic [DATA_WD-1:0] data_out,
  output logic               data_out_last,
  output logic               rd_err,
  output logic               rd_busy,
  output logic               m_axi_arvalid,
  input  logic               m_axi_arready,
  output logic [ADDR_WD-1:0] m_axi_araddr,
  output logic [7:0]         m_axi_arlen,
  output logic [2:0]         m_axi_arsize,
  output logic [1:0]         m_axi_arburst,
  input  logic               m_axi_rvalid,
  output logic               m_axi_rready,
  input  logic [DATA_WD-1:0] m_axi_rdata,
  input  logic [1:0]         m_axi_rresp,
  input  logic               m_axi_rlast
);

  localparam int unsigned OW = $clog2(MAX_OUTSTANDING) + 1;

  typedef enum logic {AR_IDLE, AR_VALID} ar_state_e;

  ar_state_e          state;
  logic [OW-1:0]      outstanding;
  logic [1:0]         skid_cnt;
  logic [DATA_WD-1:0] skid_data0, skid_data1;
  logic               skid_last0, skid_last1;

  logic desc_hs, ar_hs, r_hs, pop, beat_last, burst_done, last_err;
  logic [1:0] wr_slot;

  // Descriptor acceptance depends only on registered state, never on rd_req_valid.
  assign rd_req_ready = (state == AR_IDLE) && (outstanding < OW'(MAX_OUTSTANDING)) && !rst;
  assign desc_hs      = rd_req_valid & rd_req_ready;
  assign ar_hs        = m_axi_arvalid & m_axi_arready;

  // Skid head drives the output stream; rready is a decode of the registered count.
  assign m_axi_rready   = (skid_cnt != 2'd2);
  assign r_hs           = m_axi_rvalid & m_axi_rready;
  assign data_out_valid = (skid_cnt != 2'd0);
  assign data_out       = skid_data0;
  assign data_out_last  = skid_last0;
  assign pop            = data_out_valid & data_out_ready;

  // A beat arriving with nothing outstanding does not complete a burst.
  assign burst_done = r_hs & beat_last & (outstanding != '0);

  assign rd_busy = (state == AR_VALID) || (outstanding != '0) || (skid_cnt != 2'd0);

  // AR channel FSM with registered payload held stable while arvalid waits.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= AR_IDLE;
      m_axi_arvalid <= 1'b0;
      m_axi_araddr  <= '0;
      m_axi_arlen   <= '0;
      m_axi_arsize  <= '0;
      m_axi_arburst <= '0;
    end else begin
      case (state)
        AR_IDLE: begin
          if (desc_hs) begin
            m_axi_araddr  <= rd_req_addr;
            m_axi_arlen   <= rd_req_len;
            m_axi_arsize  <= rd_req_size;
            m_axi_arburst <= rd_req_burst;
            m_axi_arvalid <= 1'b1;
            state         <= AR_VALID;
          end
        end
        AR_VALID: begin
          if (m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            state         <= AR_IDLE;
          end
        end
        default: begin
          m_axi_arvalid <= 1'b0;
          state         <= AR_IDLE;
        end
      endcase
    end
  end

  // Bursts issued on AR whose final R beat has not yet been seen.
  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding <= '0;
    end else begin
      case ({ar_hs, burst_done})
        2'b10:   outstanding <= outstanding + OW'(1);
        2'b01:   outstanding <= outstanding - OW'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  // Slot for an incoming beat is the occupancy left after any same-cycle pop.
  assign wr_slot = skid_cnt - 2'(pop);

  // Two-entry skid buffer; entry 0 is the head.
  always_ff @(posedge clk) begin
    if (rst) begin
      skid_cnt   <= 2'd0;
      skid_data0 <= '0;
      skid_data1 <= '0;
      skid_last0 <= 1'b0;
      skid_last1 <= 1'b0;
    end else begin
      if (pop) begin
        skid_data0 <= skid_data1;
        skid_last0 <= skid_last1;
      end
      if (r_hs) begin
        if (wr_slot == 2'd0) begin
          skid_data0 <= m_axi_rdata;
          skid_last0 <= beat_last;
        end else begin
          skid_data1 <= m_axi_rdata;
          skid_last1 <= beat_last;
        end
      end
      skid_cnt <= skid_cnt + 2'(r_hs) - 2'(pop);
    end
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_err <= 1'b0;
    end else if ((r_hs && (m_axi_rresp != 2'b00)) || last_err) begin
      rd_err <= 1'b1;
    end
  end

`ifdef DMAC_RD_LAST_CHECK_EN
  localparam int unsigned PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  logic [7:0]    len_fifo [MAX_OUTSTANDING];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [7:0]    beat_cnt;
  logic          expected_last;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + PW'(1);
  endfunction

  // The FIFO occupancy equals outstanding, so no separate count is kept.
  assign expected_last = (beat_cnt == len_fifo[rd_ptr]);
  assign beat_last     = expected_last;
  assign last_err      = r_hs && (outstanding != '0) && (m_axi_rlast != expected_last);

  // Queue arlen per AR handshake and count beats of the head burst.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      if (ar_hs) begin
        len_fifo[wr_ptr] <= m_axi_arlen;
        wr_ptr           <= ptr_inc(wr_ptr);
      end
      if (r_hs && (outstanding != '0)) begin
        if (expected_last) begin
          beat_cnt <= '0;
          rd_ptr   <= ptr_inc(rd_ptr);
        end else begin
          beat_cnt <= beat_cnt + 8'd1;
        end
      end
    end
  end
`else
  assign beat_last = m_axi_rlast;
  assign last_err  = 1'b0;
`endif

endmodule

// File: tb/tb_dmac_read_initiator.sv
module tb_dmac_read_initiator;

  logic        clk;
  logic        rst;
  logic        rd_req_valid;
  logic        rd_req_ready;
  logic [31:0] rd_req_addr;
  logic [1:0]  rd_req_burst;
  logic [7:0]  rd_req_len;
  logic [2:0]  rd_req_size;
  logic        data_out_valid;
  logic        data_out_ready;
  logic [31:0] data_out;
  logic        data_out_last;
  logic        rd_err;
  logic        rd_busy;
  logic        m_axi_arvalid;
  logic        m_axi_arready;
  logic [31:0] m_axi_araddr;
  logic [7:0]  m_axi_arlen;
  logic [2:0]  m_axi_arsize;
  logic [1:0]  m_axi_arburst;
  logic        m_axi_rvalid;
  logic        m_axi_rready;
  logic [31:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;
  logic        m_axi_rlast;

  dmac_read_initiator #(.ADDR_WD(32), .DATA_WD(32), .MAX_OUTSTANDING(4)) dut (
    .clk(clk), .rst(rst),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
    .rd_req_addr(rd_req_addr), .rd_req_burst(rd_req_burst),
    .rd_req_len(rd_req_len), .rd_req_size(rd_req_size),
    .data_out_valid(data_out_valid), .data_out_ready(data_out_ready),
    .data_out(data_out), .data_out_last(data_out_last),
    .rd_err(rd_err), .rd_busy(rd_busy),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rv;
    logic [31:0] rd;
    logic        rl;
    logic [1:0]  rr;
    logic        dr;
    logic        ev;
    logic [31:0] ed;
    logic        el;
    logic        erdy;
    logic        eerr;
    logic        ebusy;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    rd_req_valid = 1'b0; m_axi_rvalid = 1'b0; m_axi_arready = 1'b0; data_out_ready = 1'b0;
    #1;
    chk("rst_req_ready", rd_req_ready, 1'b0);
    @(posedge clk); #1;
    chk("rst_arvalid", m_axi_arvalid, 1'b0);
    chk("rst_araddr", m_axi_araddr, 32'h0);
    chk("rst_arlen", m_axi_arlen, 8'h0);
    chk("rst_dov", data_out_valid, 1'b0);
    chk("rst_dout", data_out, 32'h0);
    chk("rst_dlast", data_out_last, 1'b0);
    chk("rst_err", rd_err, 1'b0);
    chk("rst_busy", rd_busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Returns #1 after the handshake edge with rd_req_valid dropped.
  task automatic send_desc(input logic [31:0] addr, input logic [7:0] len);
    int n;
    n = 0;
    @(negedge clk);
    rd_req_valid = 1'b1; rd_req_addr = addr; rd_req_len = len;
    rd_req_size = 3'd2; rd_req_burst = 2'd1;
    #1;
    while (!rd_req_ready && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    chk("desc_accept", rd_req_ready, 1'b1);
    @(posedge clk); #1;
    rd_req_valid = 1'b0;
  endtask

  initial begin
    int sent, arc, got, rsent;
    logic saw_full;

    rst = 1'b1; rd_req_valid = 1'b0; rd_req_addr = '0; rd_req_burst = '0; rd_req_len = '0;
    rd_req_size = '0; data_out_ready = 1'b0; m_axi_arready = 1'b0; m_axi_rvalid = 1'b0;
    m_axi_rdata = '0; m_axi_rresp = '0; m_axi_rlast = 1'b0;

    //            rv  rdata   rl  rr    dr   ev  edata   el  erdy eerr ebusy
    tbl[0] = '{1'b1, 32'hA0, 1'b0, 2'b00, 1'b0, 1'b1, 32'hA0, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[1] = '{1'b1, 32'hA1, 1'b0, 2'b00, 1'b0, 1'b1, 32'hA0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[2] = '{1'b1, 32'hA2, 1'b0, 2'b00, 1'b1, 1'b1, 32'hA1, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[3] = '{1'b1, 32'hA2, 1'b0, 2'b10, 1'b1, 1'b1, 32'hA2, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[4] = '{1'b1, 32'hA3, 1'b1, 2'b00, 1'b0, 1'b1, 32'hA2, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[5] = '{1'b0, 32'h00, 1'b0, 2'b00, 1'b1, 1'b1, 32'hA3, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[6] = '{1'b0, 32'h00, 1'b0, 2'b00, 1'b1, 1'b0, 32'h00, 1'b0, 1'b1, 1'b1, 1'b0};

    do_reset();

    // Single burst with arready delayed two cycles, then table-driven R phase.
    send_desc(32'h1000, 8'd3);
    chk("ar_valid", m_axi_arvalid, 1'b1);
    chk("ar_addr", m_axi_araddr, 32'h1000);
    chk("ar_len", m_axi_arlen, 8'd3);
    chk("ar_size", m_axi_arsize, 3'd2);
    chk("ar_burst", m_axi_arburst, 2'd1);
    chk("ar_req_ready_busy", rd_req_ready, 1'b0);
    chk("ar_busy", rd_busy, 1'b1);
    repeat (2) begin
      @(posedge clk); #1;
      chk("ar_hold_valid", m_axi_arvalid, 1'b1);
      chk("ar_hold_addr", m_axi_araddr, 32'h1000);
    end
    m_axi_arready = 1'b1;
    @(posedge clk); #1;
    m_axi_arready = 1'b0;
    chk("ar_done", m_axi_arvalid, 1'b0);
    chk("req_ready_after_ar", rd_req_ready, 1'b1);

    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      m_axi_rvalid = tbl[i].rv; m_axi_rdata = tbl[i].rd; m_axi_rlast = tbl[i].rl;
      m_axi_rresp = tbl[i].rr; data_out_ready = tbl[i].dr;
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_dov", i), data_out_valid, tbl[i].ev);
      if (tbl[i].ev) begin
        chk($sformatf("tbl%0d_dout", i), data_out, tbl[i].ed);
        chk($sformatf("tbl%0d_dlast", i), data_out_last, tbl[i].el);
      end
      chk($sformatf("tbl%0d_rready", i), m_axi_rready, tbl[i].erdy);
      chk($sformatf("tbl%0d_err", i), rd_err, tbl[i].eerr);
      chk($sformatf("tbl%0d_busy", i), rd_busy, tbl[i].ebusy);
    end
    m_axi_rvalid = 1'b0; m_axi_rresp = 2'b00; data_out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("err_sticky", rd_err, 1'b1);

    // Outstanding limit: five descriptors, R held off.
    do_reset();
    m_axi_arready = 1'b1;
    sent = 0; arc = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      rd_req_valid = (sent < 5); rd_req_addr = 32'h2000 + 32'(sent) * 32'h100;
      rd_req_len = 8'd0; rd_req_size = 3'd2; rd_req_burst = 2'd1;
      #1;
      if (rd_req_valid && rd_req_ready) sent++;
      if (m_axi_arvalid && m_axi_arready) arc++;
      @(posedge clk);
    end
    #1;
    chk("lim_desc_cnt", 64'(sent), 64'd4);
    chk("lim_ar_cnt", 64'(arc), 64'd4);
    chk("lim_req_ready", rd_req_ready, 1'b0);
    @(negedge clk);
    m_axi_rvalid = 1'b1; m_axi_rdata = 32'h55; m_axi_rlast = 1'b1; data_out_ready = 1'b1;
    @(posedge clk); #1;
    m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      rd_req_valid = (sent < 5);
      #1;
      if (rd_req_valid && rd_req_ready) sent++;
      if (m_axi_arvalid && m_axi_arready) arc++;
      @(posedge clk);
    end
    #1;
    rd_req_valid = 1'b0;
    chk("lim_desc_cnt5", 64'(sent), 64'd5);
    chk("lim_ar_cnt5", 64'(arc), 64'd5);

    // Backpressure: 16-beat burst, downstream ready toggling.
    do_reset();
    m_axi_arready = 1'b1;
    send_desc(32'h3000, 8'd15);
    @(posedge clk); #1;
    chk("bp_ar_done", m_axi_arvalid, 1'b0);
    got = 0; rsent = 0; saw_full = 1'b0;
    for (int c = 0; c < 100 && got < 16; c++) begin
      @(negedge clk);
      m_axi_rvalid = (rsent < 16); m_axi_rdata = 32'h100 + 32'(rsent);
      m_axi_rlast = (rsent == 15); data_out_ready = c[0];
      #1;
      if (!m_axi_rready) saw_full = 1'b1;
      if (m_axi_rvalid && m_axi_rready) rsent++;
      if (data_out_valid && data_out_ready) begin
        chk("bp_data", data_out, 32'h100 + 32'(got));
        chk("bp_last", data_out_last, (got == 15) ? 1'b1 : 1'b0);
        got++;
      end
      @(posedge clk);
    end
    #1;
    m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
    chk("bp_got", 64'(got), 64'd16);
    chk("bp_saw_full", saw_full, 1'b1);
    chk("bp_err", rd_err, 1'b0);
    chk("bp_empty", data_out_valid, 1'b0);
    chk("bp_idle", rd_busy, 1'b0);

    // Reset mid-burst after two of four beats.
    do_reset();
    m_axi_arready = 1'b1;
    send_desc(32'h4000, 8'd3);
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      m_axi_rvalid = 1'b1; m_axi_rdata = 32'hC0 + 32'(i); m_axi_rlast = 1'b0;
      @(posedge clk); #1;
    end
    m_axi_rvalid = 1'b0;
    chk("mid_dov", data_out_valid, 1'b1);
    chk("mid_busy", rd_busy, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_req_ready", rd_req_ready, 1'b0);
    @(posedge clk); #1;
    chk("mid_arvalid", m_axi_arvalid, 1'b0);
    chk("mid_dov_rst", data_out_valid, 1'b0);
    chk("mid_busy_rst", rd_busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_req_ready_after", rd_req_ready, 1'b1);

    // Early rlast on beat index 1 of a 4-beat burst.
    do_reset();
    m_axi_arready = 1'b1; data_out_ready = 1'b1;
    send_desc(32'h5000, 8'd3);
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      m_axi_rvalid = 1'b1; m_axi_rdata = 32'hB0 + 32'(i); m_axi_rlast = (i == 1);
      @(posedge clk); #1;
      chk("lc_dov", data_out_valid, 1'b1);
      chk("lc_data", data_out, 32'hB0 + 32'(i));
`ifdef DMAC_RD_LAST_CHECK_EN
      chk("lc_last", data_out_last, (i == 3) ? 1'b1 : 1'b0);
`else
      chk("lc_last", data_out_last, (i == 1) ? 1'b1 : 1'b0);
`endif
    end
    m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
    @(posedge clk); #1;
`ifdef DMAC_RD_LAST_CHECK_EN
    chk("lc_err", rd_err, 1'b1);
`else
    chk("lc_err", rd_err, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmac_read_initiator.md
Name: dmac_read_initiator

Overview:
AXI4 read-channel master for the DMA controller, the source-side counterpart of the write initiator. Accepts burst descriptors from the channel scheduler, issues them on AR, and streams R data beats to the data realignment/FIFO stage via a valid/ready stream. Tracks outstanding bursts, buffers R through a 2-entry skid buffer, and flags error responses.

Parameters:
ADDR_WD, 32, address width in bits
DATA_WD, 32, data bus width in bits (multiple of 8)
MAX_OUTSTANDING, 4, max AR bursts in flight without a completed R burst (power of 2, >=1)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
rd_req_valid  in  1  burst descriptor valid
rd_req_ready  out  1  descriptor accepted when valid&ready
rd_req_addr  in  ADDR_WD  burst start address
rd_req_burst  in  2  AXI burst type
rd_req_len  in  8  AXI len (beats-1)
rd_req_size  in  3  AXI size
data_out_valid  out  1  read beat valid
data_out_ready  in  1  downstream ready
data_out  out  DATA_WD  read beat data
data_out_last  out  1  last beat of burst (from rlast)
rd_err  out  1  sticky: non-OKAY rresp seen
rd_busy  out  1  AR pending or outstanding count nonzero or skid non-empty
m_axi_arvalid  out  1  AR valid
m_axi_arready  in  1  AR ready
m_axi_araddr  out  ADDR_WD  AR address
m_axi_arlen  out  8  AR len
m_axi_arsize  out  3  AR size
m_axi_arburst  out  2  AR burst
m_axi_rvalid  in  1  R valid
m_axi_rready  out  1  R ready
m_axi_rdata  in  DATA_WD  R data
m_axi_rresp  in  2  R response
m_axi_rlast  in  1  R last

Behaviour:
- Reset (sync, rst=1 at clk edge): arvalid=0, AR payload regs=0, outstanding=0, skid empty, data_out_valid=0, data_out=0, data_out_last=0, rd_err=0, rd_busy=0, rd_req_ready=0 during reset cycle. Reset mid-burst drops all in-flight state; no recovery of partial bursts.
- AR FSM: AR_IDLE -> AR_VALID on descriptor handshake; AR_VALID -> AR_IDLE on arvalid&arready.
- rd_req_ready = (state==AR_IDLE) & (outstanding < MAX_OUTSTANDING) & !rst. Combinational from registered state only (no path from rd_req_valid).
- Descriptor fields registered on handshake; arvalid asserted next cycle (1-cycle latency); AR payload stable while arvalid=1 and arready=0.
- outstanding counter, width clog2(MAX_OUTSTANDING)+1: +1 on AR handshake, -1 on R handshake with rlast=1, unchanged if both same cycle. Never exceeds MAX_OUTSTANDING; never underflows (R beat with outstanding==0 is ignored for counting).
- R path: 2-entry skid buffer. rready = registered "skid entry count < 2"; beat captured on rvalid&rready carrying {rdata, rlast}. data_out_* driven from head entry; pop on data_out_valid&data_out_ready. Simultaneous push/pop at count 2 not possible (rready=0); at count 1 keeps count 1. Min latency R handshake -> data_out_valid: 1 cycle. Full throughput 1 beat/cycle when data_out_ready held high.
- rresp != OKAY(2'b00) on any R handshake sets rd_err; cleared only by reset. Data still forwarded unchanged.
- rd_busy = (state==AR_VALID) | (outstanding!=0) | skid non-empty.

Optional Feature:
DMAC_RD_LAST_CHECK_EN: when defined, a MAX_OUTSTANDING-deep FIFO stores arlen per AR handshake and a beat counter checks R beats; rlast early or missing at expected beat sets rd_err, and data_out_last is generated from the expected count (rlast ignored). When undefined, no FIFO/counter; data_out_last = captured rlast.

Test Plan:
- Single burst: addr=0x1000, len=3, size=2, burst=INCR, slave arready after 2 cycles, 4 R beats 0xA0..0xA3 -> one AR with araddr=0x1000 arlen=3, data_out beats 0xA0..0xA3 in order, last on 0xA3, rd_err=0, rd_busy falls after final pop.
- Outstanding limit: 5 back-to-back descriptors, R held off -> 4 AR handshakes, rd_req_ready=0 with outstanding=4; after first rlast, 5th descriptor accepted.
- Backpressure: 16-beat burst, data_out_ready toggling 1/0 every cycle -> no beat lost/duplicated, rready drops when skid holds 2.
- Error: beat 2 of len=3 burst with rresp=2'b10 -> rd_err=1 from next cycle, all 4 beats forwarded, stays 1 until rst.
- Reset mid-burst: rst after AR handshake and 2 of 4 beats -> next cycle arvalid=0, data_out_valid=0, outstanding=0, rd_busy=0.
- With DMAC_RD_LAST_CHECK_EN: len=3 with rlast on beat 2 -> rd_err=1, data_out_last asserted on 4th beat only.
